// File: rtl/video_timing_if.sv
// Raster timing bundle between the timing generator (master) and video sources (slave).
// With VIDEO_TIMING_FRAME_COUNT_EN defined the bundle also carries a 16-bit frame counter.
interface video_timing_if #(
    parameter int COORDSPC = 16
);
    logic                       run;
    logic                       running;
    logic signed [COORDSPC-1:0] sx;
    logic signed [COORDSPC-1:0] sy;
    logic                       hsync;
    logic                       vsync;
    logic                       video_enable;
    logic                       frame_start;
    logic                       line_start;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    logic [15:0]                frame_count;

    modport master (
        input  run,
        output running, sx, sy, hsync, vsync, video_enable, frame_start, line_start, frame_count
    );
    modport slave (
        output run,
        input  running, sx, sy, hsync, vsync, video_enable, frame_start, line_start, frame_count
    );
`else
    modport master (
        input  run,
        output running, sx, sy, hsync, vsync, video_enable, frame_start, line_start
    );
    modport slave (
        output run,
        input  running, sx, sy, hsync, vsync, video_enable, frame_start, line_start
    );
`endif
endinterface

// File: rtl/video_timing_gen.sv
// Parameterised raster timing generator with frame-boundary run/stop control.
// Optional VIDEO_TIMING_FRAME_COUNT_EN adds a free-running 16-bit frame counter.
module video_timing_gen #(
    parameter int COORDSPC  = 16,
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 110,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 220,
    parameter int V_ACTIVE  = 720,
    parameter int V_FP      = 5,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic           video_clk_pix,
    input  logic           video_rst_n,
    video_timing_if.master vt
);
    localparam logic signed [COORDSPC-1:0] H_STA  = COORDSPC'(-(H_FP + H_SYNC + H_BP));
    localparam logic signed [COORDSPC-1:0] HS_STA = COORDSPC'(-(H_FP + H_SYNC + H_BP) + H_FP);
    localparam logic signed [COORDSPC-1:0] HS_END = COORDSPC'(-(H_FP + H_SYNC + H_BP) + H_FP + H_SYNC);
    localparam logic signed [COORDSPC-1:0] H_END  = COORDSPC'(H_ACTIVE - 1);
    localparam logic signed [COORDSPC-1:0] V_STA  = COORDSPC'(-(V_FP + V_SYNC + V_BP));
    localparam logic signed [COORDSPC-1:0] VS_STA = COORDSPC'(-(V_FP + V_SYNC + V_BP) + V_FP);
    localparam logic signed [COORDSPC-1:0] VS_END = COORDSPC'(-(V_FP + V_SYNC + V_BP) + V_FP + V_SYNC);
    localparam logic signed [COORDSPC-1:0] V_END  = COORDSPC'(V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t                     state_reg, state_next;
    logic signed [COORDSPC-1:0] sx_reg, sx_next;
    logic signed [COORDSPC-1:0] sy_reg, sy_next;
    logic                       hsync_reg, hsync_next;
    logic                       vsync_reg, vsync_next;
    logic                       de_reg, de_next;
    logic                       fs_reg, fs_next;
    logic                       ls_reg, ls_next;
    logic                       running_reg, running_next;

    // Every flag is derived from the next-cycle coordinates so it lands in the same cycle as sx/sy.
    always_comb begin
        state_next = state_reg;
        sx_next    = sx_reg;
        sy_next    = sy_reg;

        case (state_reg)
            IDLE:     if (vt.run) state_next = RUN;
            RUN:      if (!vt.run) state_next = STOPPING;
            STOPPING: begin
                if (vt.run)
                    state_next = RUN;
                else if (sx_reg == H_END && sy_reg == V_END)
                    state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase

        if (state_reg == RUN || state_reg == STOPPING) begin
            if (sx_reg == H_END) begin
                sx_next = H_STA;
                sy_next = (sy_reg == V_END) ? V_STA : sy_reg + COORDSPC'(1);
            end else begin
                sx_next = sx_reg + COORDSPC'(1);
            end
        end else begin
            sx_next = H_STA;
            sy_next = V_STA;
        end

        running_next = (state_next != IDLE);
        hsync_next   = (running_next && sx_next >= HS_STA && sx_next < HS_END) ? HSYNC_POL : ~HSYNC_POL;
        vsync_next   = (running_next && sy_next >= VS_STA && sy_next < VS_END) ? VSYNC_POL : ~VSYNC_POL;
        de_next      = running_next && !sx_next[COORDSPC-1] && !sy_next[COORDSPC-1];
        ls_next      = running_next && (sx_next == H_STA);
        fs_next      = ls_next && (sy_next == V_STA);
    end

    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            state_reg   <= IDLE;
            sx_reg      <= H_STA;
            sy_reg      <= V_STA;
            hsync_reg   <= ~HSYNC_POL;
            vsync_reg   <= ~VSYNC_POL;
            de_reg      <= 1'b0;
            fs_reg      <= 1'b0;
            ls_reg      <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sx_reg      <= sx_next;
            sy_reg      <= sy_next;
            hsync_reg   <= hsync_next;
            vsync_reg   <= vsync_next;
            de_reg      <= de_next;
            fs_reg      <= fs_next;
            ls_reg      <= ls_next;
            running_reg <= running_next;
        end
    end

    assign vt.running      = running_reg;
    assign vt.sx           = sx_reg;
    assign vt.sy           = sy_reg;
    assign vt.hsync        = hsync_reg;
    assign vt.vsync        = vsync_reg;
    assign vt.video_enable = de_reg;
    assign vt.frame_start  = fs_reg;
    assign vt.line_start   = ls_reg;

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    logic [15:0] frame_count_reg;

    // Counts at the end of each frame_start cycle, so the strobe cycle shows the pre-increment value.
    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n)
            frame_count_reg <= 16'd0;
        else if (fs_reg)
            frame_count_reg <= frame_count_reg + 16'd1;
    end

    assign vt.frame_count = frame_count_reg;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: default 720p instance for line-level timing, small 4x2 instance (inverted syncs)
// for table vectors, stop/restart sequences, random run toggling and asynchronous reset.
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    localparam int FC_ON = 1;
`else
    localparam int FC_ON = 0;
`endif

    typedef struct packed {
        int h_act; int h_fp; int h_sync; int h_bp;
        int v_act; int v_fp; int v_sync; int v_bp;
        bit hpol;  bit vpol;
    } geom_t;

    typedef struct packed {
        bit active; bit stopping; int pos; int fcount;
    } mstate_t;

    typedef struct packed {
        bit running; int sx; int sy; bit hsync; bit vsync; bit ve; bit fs; bit ls; int fc;
    } mout_t;

    typedef struct {
        bit    run;
        mout_t exp;
    } vec_t;

    video_timing_if #(.COORDSPC(16)) ifa ();
    video_timing_if #(.COORDSPC(16)) ifb ();

    video_timing_gen u_a (
        .video_clk_pix (clk),
        .video_rst_n   (rst_n),
        .vt            (ifa)
    );

    video_timing_gen #(
        .COORDSPC(16),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) u_b (
        .video_clk_pix (clk),
        .video_rst_n   (rst_n),
        .vt            (ifb)
    );

    int      n_vec = 0;
    int      n_err = 0;
    geom_t   ga, gb;
    mstate_t ms_a, ms_b;

    // Reference: a frame is a linear pixel index; coordinates come from div/mod of that index.
    function automatic mout_t m_out(geom_t g, mstate_t s);
        mout_t o;
        int ht     = g.h_act + g.h_fp + g.h_sync + g.h_bp;
        int hsta   = -(g.h_fp + g.h_sync + g.h_bp);
        int vsta   = -(g.v_fp + g.v_sync + g.v_bp);
        int hs_sta = hsta + g.h_fp;
        int vs_sta = vsta + g.v_fp;
        int p      = s.active ? s.pos : 0;
        o.running = s.active;
        o.sx      = hsta + p % ht;
        o.sy      = vsta + p / ht;
        o.hsync   = (s.active && o.sx >= hs_sta && o.sx < hs_sta + g.h_sync) ? g.hpol : !g.hpol;
        o.vsync   = (s.active && o.sy >= vs_sta && o.sy < vs_sta + g.v_sync) ? g.vpol : !g.vpol;
        o.ve      = s.active && o.sx >= 0 && o.sy >= 0;
        o.fs      = s.active && p == 0;
        o.ls      = s.active && (p % ht) == 0;
        o.fc      = FC_ON ? s.fcount : 0;
        return o;
    endfunction

    function automatic mstate_t m_step(geom_t g, mstate_t s, bit run);
        mstate_t n     = s;
        mout_t   o     = m_out(g, s);
        int      total = (g.h_act + g.h_fp + g.h_sync + g.h_bp) * (g.v_act + g.v_fp + g.v_sync + g.v_bp);
        n.fcount = (s.fcount + (o.fs ? 1 : 0)) % 65536;
        if (!s.active) begin
            if (run) begin
                n.active = 1'b1; n.pos = 0; n.stopping = 1'b0;
            end
        end else if (s.stopping && !run && s.pos == total - 1) begin
            n.active = 1'b0; n.pos = 0; n.stopping = 1'b0;
        end else begin
            n.pos      = (s.pos + 1) % total;
            n.stopping = !run;
        end
        return n;
    endfunction

    function automatic mout_t dut_a();
        mout_t o;
        o.running = ifa.running; o.sx = int'(ifa.sx); o.sy = int'(ifa.sy);
        o.hsync = ifa.hsync; o.vsync = ifa.vsync; o.ve = ifa.video_enable;
        o.fs = ifa.frame_start; o.ls = ifa.line_start;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        o.fc = int'(ifa.frame_count);
`else
        o.fc = 0;
`endif
        return o;
    endfunction

    function automatic mout_t dut_b();
        mout_t o;
        o.running = ifb.running; o.sx = int'(ifb.sx); o.sy = int'(ifb.sy);
        o.hsync = ifb.hsync; o.vsync = ifb.vsync; o.ve = ifb.video_enable;
        o.fs = ifb.frame_start; o.ls = ifb.line_start;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        o.fc = int'(ifb.frame_count);
`else
        o.fc = 0;
`endif
        return o;
    endfunction

    task automatic check(input string name, input mout_t exp, input mout_t got);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got run=%0d sx=%0d sy=%0d hs=%0d vs=%0d de=%0d fs=%0d ls=%0d fc=%0d, expected run=%0d sx=%0d sy=%0d hs=%0d vs=%0d de=%0d fs=%0d ls=%0d fc=%0d",
                     name, got.running, got.sx, got.sy, got.hsync, got.vsync, got.ve, got.fs, got.ls, got.fc,
                     exp.running, exp.sx, exp.sy, exp.hsync, exp.vsync, exp.ve, exp.fs, exp.ls, exp.fc);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick_a(input bit r);
        ifa.run = r;
        ms_a = m_step(ga, ms_a, r);
        @(negedge clk);
        check("model_a", m_out(ga, ms_a), dut_a());
    endtask

    task automatic tick_b(input bit r);
        ifb.run = r;
        ms_b = m_step(gb, ms_b, r);
        @(negedge clk);
        check("model_b", m_out(gb, ms_b), dut_b());
    endtask

    initial begin
        vec_t  tbl [9];
        mout_t o, prev, exp;
        int    last, hs_cnt, hs_min, hs_max, n, n_idle, bad_gap, n_fs, k;
        bit    r;

        ga = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};
        gb = '{4, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0};
        ms_a = '0;
        ms_b = '0;
        rst_n = 1'b0;
        ifa.run = 1'b0;
        ifb.run = 1'b0;

        // Small geometry: H_STA=-3 HS=-2 H_END=3, V_STA=-3 VS=-2 V_END=1; syncs active-low
        tbl[0] = '{1'b0, '{1'b0, -3, -3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0}};
        tbl[1] = '{1'b1, '{1'b1, -3, -3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0}};
        tbl[2] = '{1'b1, '{1'b1, -2, -3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FC_ON}};
        tbl[3] = '{1'b0, '{1'b1, -1, -3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FC_ON}};
        tbl[4] = '{1'b1, '{1'b1,  0, -3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FC_ON}};
        tbl[5] = '{1'b1, '{1'b1,  1, -3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FC_ON}};
        tbl[6] = '{1'b1, '{1'b1,  2, -3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FC_ON}};
        tbl[7] = '{1'b1, '{1'b1,  3, -3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FC_ON}};
        tbl[8] = '{1'b1, '{1'b1, -3, -2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FC_ON}};

        repeat (3) @(negedge clk);
        check("reset_a", m_out(ga, ms_a), dut_a());
        check("reset_b", m_out(gb, ms_b), dut_b());
        check_int("reset_a_sx", int'(ifa.sx), -370);
        check_int("reset_a_sy", int'(ifa.sy), -30);
        rst_n = 1'b1;

        // Default geometry: first RUN cycle, then two lines of free-running
        tick_a(1'b1);
        exp = '{1'b1, -370, -30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
        check("first_run_a", exp, dut_a());
        last = 0; hs_cnt = 0; hs_min = 9999; hs_max = -9999;
        for (int c = 1; c <= 3300; c++) begin
            tick_a(1'b1);
            o = dut_a();
            if (o.ls) begin
                check_int("line_period", c - last, 1650);
                last = c;
            end
            if (o.sy == -30 && o.hsync) begin
                hs_cnt++;
                if (o.sx < hs_min) hs_min = o.sx;
                if (o.sx > hs_max) hs_max = o.sx;
            end
        end
        check_int("hsync_width", hs_cnt, 40);
        check_int("hsync_first_sx", hs_min, -260);
        check_int("hsync_last_sx", hs_max, -221);
        ifa.run = 1'b0;

        for (int i = 0; i < 9; i++) begin
            ifb.run = tbl[i].run;
            ms_b = m_step(gb, ms_b, tbl[i].run);
            @(negedge clk);
            check($sformatf("tbl%0d", i), tbl[i].exp, dut_b());
        end

        // Drop run mid-frame: frame must finish at (3,1) before IDLE
        n = 0;
        prev = dut_b();
        while (dut_b().running && n < 100) begin
            prev = dut_b();
            tick_b(1'b0);
            n++;
        end
        check_int("stop_within_bound", int'(n < 100), 1);
        check_int("stop_last_sx", prev.sx, 3);
        check_int("stop_last_sy", prev.sy, 1);
        o = dut_b();
        check_int("idle_sx", o.sx, -3);
        check_int("idle_sy", o.sy, -3);

        // Re-raise run during STOPPING: never idle, frame_start every 35 cycles
        n_idle = 0; bad_gap = 0; n_fs = 0; last = -1;
        for (int c = 0; c < 98; c++) begin
            tick_b(c < 10 || c >= 18);
            o = dut_b();
            if (!o.running) n_idle++;
            if (o.fs) begin
                if (last >= 0 && c - last != 35) bad_gap++;
                last = c;
                n_fs++;
            end
        end
        check_int("reraise_idle_cycles", n_idle, 0);
        check_int("reraise_bad_gaps", bad_gap, 0);
        check_int("reraise_frame_starts", n_fs, 3);

        r = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) r = !r;
            tick_b(r);
        end

        // Reach an active-area pixel, then reset asynchronously between edges
        n = 0;
        o = m_out(gb, ms_b);
        while (!(o.ve && o.sx == 1) && n < 500) begin
            tick_b(1'b1);
            o = m_out(gb, ms_b);
            n++;
        end
        check_int("reach_active_line", int'(n < 500), 1);
        #2;
        rst_n = 1'b0;
        #1;
        ms_b = '0;
        check("async_reset", m_out(gb, ms_b), dut_b());
        @(negedge clk);
        check("reset_held", m_out(gb, ms_b), dut_b());
        rst_n = 1'b1;
        k = 0;
        for (int c = 0; c < 80; c++) begin
            tick_b(1'b1);
            o = dut_b();
            if (c == 0) check_int("fs_after_release", int'(o.fs), 1);
            if (o.fs) begin
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
                check_int("frame_count_seq", o.fc, k);
`endif
                k++;
            end
        end
        check_int("frames_after_release", k, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
